// File: rtl/regfile_scoreboard_if.sv
// Issue, operand-return and writeback signals of the register file read side.
// master = issue/writeback driver; slave = the register file itself.
interface regfile_scoreboard_if #(
   parameter int WORD_LENGTH = 16,
   parameter int ADDR_WIDTH  = 3
);
   logic                   issue_valid;
   logic [ADDR_WIDTH-1:0]  issue_rs1;
   logic [ADDR_WIDTH-1:0]  issue_rs2;
   logic [ADDR_WIDTH-1:0]  issue_rd;
   logic                   issue_wr;
   logic                   issue_ready;
   logic [WORD_LENGTH-1:0] rd1_data;
   logic [WORD_LENGTH-1:0] rd2_data;
   logic                   data_valid;
   logic                   wb_valid;
   logic [ADDR_WIDTH-1:0]  wb_addr;
   logic [WORD_LENGTH-1:0] wb_data;

   modport master (
      output issue_valid, issue_rs1, issue_rs2, issue_rd, issue_wr,
      output wb_valid, wb_addr, wb_data,
      input  issue_ready, rd1_data, rd2_data, data_valid
   );

   modport slave (
      input  issue_valid, issue_rs1, issue_rs2, issue_rd, issue_wr,
      input  wb_valid, wb_addr, wb_data,
      output issue_ready, rd1_data, rd2_data, data_valid
   );
endinterface

// File: rtl/regfile_scoreboard.sv
// Register file read side with busy-bit scoreboard; REGFILE_BYPASS_EN forwards same-cycle writeback.
// Latency: operands registered, valid one cycle after the accepting edge.
// Backpressure: issue_ready drops combinationally on RAW/WAW against pending writes.
module regfile_scoreboard #(
   parameter int WORD_LENGTH = 16,
   parameter int ADDR_WIDTH  = 3
) (
   input  logic                    clk,
   input  logic                    rst,
   regfile_scoreboard_if.slave     rf,
   output logic [2**ADDR_WIDTH-1:0] busy,
   output logic [ADDR_WIDTH:0]     pending_cnt,
   output logic                    wb_err
);
   localparam int DEPTH = 2**ADDR_WIDTH;

   logic [WORD_LENGTH-1:0] mem [DEPTH];
   logic                   wb_we;
   logic                   byp1, byp2, bypd;
   logic                   haz1, haz2, hazd;
   logic                   accept;
   logic [WORD_LENGTH-1:0] op1, op2;
   logic [DEPTH-1:0]       busy_nxt;
   logic [ADDR_WIDTH:0]    cnt_nxt;

   assign wb_we = rf.wb_valid && (rf.wb_addr != '0);

`ifdef REGFILE_BYPASS_EN
   assign byp1 = wb_we && (rf.wb_addr == rf.issue_rs1);
   assign byp2 = wb_we && (rf.wb_addr == rf.issue_rs2);
   assign bypd = wb_we && (rf.wb_addr == rf.issue_rd);
`else
   assign byp1 = 1'b0;
   assign byp2 = 1'b0;
   assign bypd = 1'b0;
`endif

   assign haz1 = (rf.issue_rs1 != '0) && busy[rf.issue_rs1] && !byp1;
   assign haz2 = (rf.issue_rs2 != '0) && busy[rf.issue_rs2] && !byp2;
   assign hazd = rf.issue_wr && (rf.issue_rd != '0) && busy[rf.issue_rd] && !bypd;

   assign rf.issue_ready = !(haz1 || haz2 || hazd);
   assign accept         = rf.issue_valid && rf.issue_ready;

   assign op1 = (rf.issue_rs1 == '0) ? '0 : (byp1 ? rf.wb_data : mem[rf.issue_rs1]);
   assign op2 = (rf.issue_rs2 == '0) ? '0 : (byp2 ? rf.wb_data : mem[rf.issue_rs2]);

   // Clear before set so a same-cycle issue to the written address keeps the bit.
   always_comb begin
      busy_nxt = busy;
      if (wb_we)
         busy_nxt[rf.wb_addr] = 1'b0;
      if (accept && rf.issue_wr && (rf.issue_rd != '0))
         busy_nxt[rf.issue_rd] = 1'b1;
      busy_nxt[0] = 1'b0;
   end

   always_comb begin
      cnt_nxt = '0;
      for (int i = 0; i < DEPTH; i++)
         cnt_nxt = cnt_nxt + (ADDR_WIDTH+1)'(busy_nxt[i]);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++)
            mem[i] <= '0;
         busy        <= '0;
         pending_cnt <= '0;
         wb_err      <= 1'b0;
         rf.rd1_data   <= '0;
         rf.rd2_data   <= '0;
         rf.data_valid <= 1'b0;
      end else begin
         if (wb_we) begin
            mem[rf.wb_addr] <= rf.wb_data;
            if (!busy[rf.wb_addr])
               wb_err <= 1'b1;
         end
         busy          <= busy_nxt;
         pending_cnt   <= cnt_nxt;
         rf.data_valid <= accept;
         if (accept) begin
            rf.rd1_data <= op1;
            rf.rd2_data <= op2;
         end
      end
   end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard; expected values are hand-derived per scenario.
module tb_regfile_scoreboard;
   logic       clk;
   logic       rst;
   logic [7:0] busy;
   logic [3:0] pending_cnt;
   logic       wb_err;
   int         n_chk;
   int         n_pass;

   regfile_scoreboard_if #(.WORD_LENGTH(16), .ADDR_WIDTH(3)) rf_if ();

   regfile_scoreboard #(.WORD_LENGTH(16), .ADDR_WIDTH(3)) dut (
      .clk         (clk),
      .rst         (rst),
      .rf          (rf_if.slave),
      .busy        (busy),
      .pending_cnt (pending_cnt),
      .wb_err      (wb_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      rf_if.issue_valid = 1'b0;
      rf_if.issue_rs1   = 3'd0;
      rf_if.issue_rs2   = 3'd0;
      rf_if.issue_rd    = 3'd0;
      rf_if.issue_wr    = 1'b0;
      rf_if.wb_valid    = 1'b0;
      rf_if.wb_addr     = 3'd0;
      rf_if.wb_data     = 16'h0;
   endtask

   task automatic issue(input logic [2:0] rs1, input logic [2:0] rs2,
                        input logic [2:0] rd, input logic wr);
      rf_if.issue_valid = 1'b1;
      rf_if.issue_rs1   = rs1;
      rf_if.issue_rs2   = rs2;
      rf_if.issue_rd    = rd;
      rf_if.issue_wr    = wr;
   endtask

   task automatic wb(input logic [2:0] addr, input logic [15:0] data);
      rf_if.wb_valid = 1'b1;
      rf_if.wb_addr  = addr;
      rf_if.wb_data  = data;
   endtask

   task automatic test_reset();
      idle();
      rst = 1'b0;
      #3;
      n_chk++; if (busy !== 8'h00) $display("FAIL reset_busy got %h want 00", busy); else n_pass++;
      n_chk++; if (pending_cnt !== 4'd0) $display("FAIL reset_cnt got %0d want 0", pending_cnt); else n_pass++;
      n_chk++; if (rf_if.data_valid !== 1'b0) $display("FAIL reset_dv got %b want 0", rf_if.data_valid); else n_pass++;
      n_chk++; if (rf_if.rd1_data !== 16'h0 || rf_if.rd2_data !== 16'h0)
         $display("FAIL reset_ops got %h/%h want 0000/0000", rf_if.rd1_data, rf_if.rd2_data); else n_pass++;
      n_chk++; if (wb_err !== 1'b0) $display("FAIL reset_wberr got %b want 0", wb_err); else n_pass++;
      #5 rst = 1'b1;
      #1;
      n_chk++; if (rf_if.issue_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", rf_if.issue_ready); else n_pass++;
      cyc();
   endtask

   task automatic test_first_issue();
      issue(3'd3, 3'd0, 3'd0, 1'b0);
      #1;
      n_chk++; if (rf_if.issue_ready !== 1'b1) $display("FAIL first_ready got %b want 1", rf_if.issue_ready); else n_pass++;
      cyc();
      idle();
      n_chk++; if (rf_if.data_valid !== 1'b1) $display("FAIL first_dv got %b want 1", rf_if.data_valid); else n_pass++;
      n_chk++; if (rf_if.rd1_data !== 16'h0 || rf_if.rd2_data !== 16'h0)
         $display("FAIL first_ops got %h/%h want 0000/0000", rf_if.rd1_data, rf_if.rd2_data); else n_pass++;
      n_chk++; if (pending_cnt !== 4'd0) $display("FAIL first_cnt got %0d want 0", pending_cnt); else n_pass++;
      cyc();
      n_chk++; if (rf_if.data_valid !== 1'b0) $display("FAIL first_dv_pulse got %b want 0", rf_if.data_valid); else n_pass++;
   endtask

   task automatic test_raw();
      issue(3'd0, 3'd0, 3'd2, 1'b1);
      cyc();
      n_chk++; if (busy !== 8'h04 || pending_cnt !== 4'd1)
         $display("FAIL raw_set got busy=%h cnt=%0d want 04/1", busy, pending_cnt); else n_pass++;
      issue(3'd2, 3'd0, 3'd0, 1'b0);
      #1;
      n_chk++; if (rf_if.issue_ready !== 1'b0) $display("FAIL raw_stall got %b want 0", rf_if.issue_ready); else n_pass++;
      cyc();
      n_chk++; if (rf_if.data_valid !== 1'b0) $display("FAIL raw_stall_dv got %b want 0", rf_if.data_valid); else n_pass++;
      wb(3'd2, 16'hBEEF);
      #1;
`ifdef REGFILE_BYPASS_EN
      n_chk++; if (rf_if.issue_ready !== 1'b1) $display("FAIL raw_wb_ready got %b want 1", rf_if.issue_ready); else n_pass++;
      cyc();
      idle();
`else
      n_chk++; if (rf_if.issue_ready !== 1'b0) $display("FAIL raw_wb_ready got %b want 0", rf_if.issue_ready); else n_pass++;
      cyc();
      rf_if.wb_valid = 1'b0;
      n_chk++; if (rf_if.data_valid !== 1'b0) $display("FAIL raw_wb_dv got %b want 0", rf_if.data_valid); else n_pass++;
      n_chk++; if (rf_if.issue_ready !== 1'b1) $display("FAIL raw_release got %b want 1", rf_if.issue_ready); else n_pass++;
      cyc();
      idle();
`endif
      n_chk++; if (rf_if.data_valid !== 1'b1 || rf_if.rd1_data !== 16'hBEEF)
         $display("FAIL raw_data got dv=%b rd1=%h want 1/beef", rf_if.data_valid, rf_if.rd1_data); else n_pass++;
      n_chk++; if (busy !== 8'h00 || pending_cnt !== 4'd0 || wb_err !== 1'b0)
         $display("FAIL raw_clear got busy=%h cnt=%0d err=%b want 00/0/0", busy, pending_cnt, wb_err); else n_pass++;
   endtask

   task automatic test_zero_reg();
      issue(3'd0, 3'd0, 3'd0, 1'b1);
      #1;
      n_chk++; if (rf_if.issue_ready !== 1'b1) $display("FAIL zero_ready got %b want 1", rf_if.issue_ready); else n_pass++;
      cyc();
      idle();
      wb(3'd0, 16'hFFFF);
      n_chk++; if (busy !== 8'h00 || pending_cnt !== 4'd0)
         $display("FAIL zero_busy got busy=%h cnt=%0d want 00/0", busy, pending_cnt); else n_pass++;
      cyc();
      idle();
      issue(3'd0, 3'd0, 3'd0, 1'b0);
      cyc();
      idle();
      n_chk++; if (rf_if.rd1_data !== 16'h0 || rf_if.rd2_data !== 16'h0 || rf_if.data_valid !== 1'b1)
         $display("FAIL zero_read got %h/%h dv=%b want 0000/0000/1", rf_if.rd1_data, rf_if.rd2_data, rf_if.data_valid); else n_pass++;
      n_chk++; if (wb_err !== 1'b0) $display("FAIL zero_wberr got %b want 0", wb_err); else n_pass++;
   endtask

   task automatic test_wb_nonbusy();
      wb(3'd5, 16'h1234);
      cyc();
      idle();
      n_chk++; if (wb_err !== 1'b1) $display("FAIL nonbusy_err got %b want 1", wb_err); else n_pass++;
      issue(3'd5, 3'd5, 3'd0, 1'b0);
      cyc();
      idle();
      n_chk++; if (rf_if.rd1_data !== 16'h1234 || rf_if.rd2_data !== 16'h1234)
         $display("FAIL nonbusy_read got %h/%h want 1234/1234", rf_if.rd1_data, rf_if.rd2_data); else n_pass++;
   endtask

   task automatic test_read_during_write();
      logic [15:0] exp_rdw;
`ifdef REGFILE_BYPASS_EN
      exp_rdw = 16'h5555;
`else
      exp_rdw = 16'h1234;
`endif
      issue(3'd5, 3'd0, 3'd0, 1'b0);
      wb(3'd5, 16'h5555);
      cyc();
      idle();
      n_chk++; if (rf_if.rd1_data !== exp_rdw) $display("FAIL rdw_old got %h want %h", rf_if.rd1_data, exp_rdw); else n_pass++;
      issue(3'd0, 3'd5, 3'd0, 1'b0);
      cyc();
      idle();
      n_chk++; if (rf_if.rd2_data !== 16'h5555) $display("FAIL rdw_new got %h want 5555", rf_if.rd2_data); else n_pass++;
   endtask

   task automatic test_same_cycle();
`ifdef REGFILE_BYPASS_EN
      issue(3'd0, 3'd0, 3'd4, 1'b1);
      cyc();
      idle();
`endif
      issue(3'd0, 3'd0, 3'd4, 1'b1);
      wb(3'd4, 16'h4444);
      #1;
      n_chk++; if (rf_if.issue_ready !== 1'b1) $display("FAIL same_ready got %b want 1", rf_if.issue_ready); else n_pass++;
      cyc();
      idle();
      n_chk++; if (busy !== 8'h10 || pending_cnt !== 4'd1)
         $display("FAIL same_setwins got busy=%h cnt=%0d want 10/1", busy, pending_cnt); else n_pass++;
      wb(3'd4, 16'h4444);
      cyc();
      idle();
      n_chk++; if (busy !== 8'h00 || pending_cnt !== 4'd0)
         $display("FAIL same_clear got busy=%h cnt=%0d want 00/0", busy, pending_cnt); else n_pass++;
      issue(3'd4, 3'd2, 3'd0, 1'b0);
      cyc();
      idle();
      n_chk++; if (rf_if.rd1_data !== 16'h4444 || rf_if.rd2_data !== 16'hBEEF)
         $display("FAIL same_data got %h/%h want 4444/beef", rf_if.rd1_data, rf_if.rd2_data); else n_pass++;
   endtask

   task automatic test_back_to_back_reset();
      logic [2:0] order [7];
      order = '{3'd1, 3'd2, 3'd3, 3'd6, 3'd7, 3'd5, 3'd4};
      for (int k = 0; k < 7; k++) begin
         issue(order[k], order[k], order[k], 1'b1);
         cyc();
         n_chk++; if (rf_if.data_valid !== 1'b1 || pending_cnt !== 4'(k + 1))
            $display("FAIL b2b_%0d got dv=%b cnt=%0d want 1/%0d", k, rf_if.data_valid, pending_cnt, k + 1); else n_pass++;
      end
      idle();
      n_chk++; if (busy !== 8'hFE || rf_if.rd1_data !== 16'h4444 || rf_if.rd2_data !== 16'h4444)
         $display("FAIL fill got busy=%h ops=%h/%h want fe/4444/4444", busy, rf_if.rd1_data, rf_if.rd2_data); else n_pass++;
      rf_if.issue_rs1 = 3'd3;
      #1;
      n_chk++; if (rf_if.issue_ready !== 1'b0) $display("FAIL fill_stall got %b want 0", rf_if.issue_ready); else n_pass++;
      #1 rst = 1'b0;
      #1;
      n_chk++; if (busy !== 8'h00 || pending_cnt !== 4'd0 || wb_err !== 1'b0)
         $display("FAIL midrst_state got busy=%h cnt=%0d err=%b want 00/0/0", busy, pending_cnt, wb_err); else n_pass++;
      n_chk++; if (rf_if.rd1_data !== 16'h0 || rf_if.rd2_data !== 16'h0 || rf_if.data_valid !== 1'b0)
         $display("FAIL midrst_ops got %h/%h dv=%b want 0000/0000/0", rf_if.rd1_data, rf_if.rd2_data, rf_if.data_valid); else n_pass++;
      #1 rst = 1'b1;
      #1;
      n_chk++; if (rf_if.issue_ready !== 1'b1) $display("FAIL midrst_ready got %b want 1", rf_if.issue_ready); else n_pass++;
      idle();
      cyc();
      wb(3'd6, 16'h6666);
      cyc();
      idle();
      n_chk++; if (wb_err !== 1'b1 || busy !== 8'h00)
         $display("FAIL late_wb got err=%b busy=%h want 1/00", wb_err, busy); else n_pass++;
      issue(3'd6, 3'd7, 3'd0, 1'b0);
      cyc();
      idle();
      n_chk++; if (rf_if.rd1_data !== 16'h6666 || rf_if.rd2_data !== 16'h0)
         $display("FAIL late_read got %h/%h want 6666/0000", rf_if.rd1_data, rf_if.rd2_data); else n_pass++;
   endtask

   initial begin
      n_chk  = 0;
      n_pass = 0;
      test_reset();
      test_first_issue();
      test_raw();
      test_zero_reg();
      test_wb_nonbusy();
      test_read_during_write();
      test_same_cycle();
      test_back_to_back_reset();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
